// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the lap stopwatch
//
// Purpose : state encoding, BCD digit geometry and the preset clamp helper
//           used by lap_stopwatch and bcd_digit.
// Ports   : none (package).
package stopwatch_pkg;

    localparam int BCD_W       = 4;
    localparam int FRAC_DIGITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } sw_state_e;

    // Non-BCD nibbles (A..F) saturate to 9 so a bad preset still counts sanely.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit up/down counter with carry/borrow chain
//
// Purpose : one decimal digit of the stopwatch time. Counts by one when
//           cin_i is high, in the direction given by up_i, and reports the
//           carry (up, 9->0) or borrow (down, 0->9) for the next digit.
// Ports   : clk, resetn    - clock, synchronous active-low reset
//           clr_i          - synchronous clear to 0 (highest after reset)
//           load_i         - load load_val_i (below clear)
//           load_val_i     - BCD value to load
//           cin_i          - carry/borrow in: count this cycle
//           up_i           - 1 = count up, 0 = count down
//           q_o            - registered digit value
//           nxt_o          - value the digit takes if it counts this cycle
//           cout_o         - carry/borrow out to the next digit
import stopwatch_pkg::*;

module bcd_digit (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             cin_i,
    input  logic             up_i,
    output logic [BCD_W-1:0] q_o,
    output logic [BCD_W-1:0] nxt_o,
    output logic             cout_o
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        nxt_o  = q_q;
        cout_o = 1'b0;
        if (cin_i) begin
            if (up_i) begin
                if (q_q == 4'd9) begin
                    nxt_o  = 4'd0;
                    cout_o = 1'b1;
                end else begin
                    nxt_o = q_q + 4'd1;
                end
            end else begin
                if (q_q == 4'd0) begin
                    nxt_o  = 4'd9;
                    cout_o = 1'b1;
                end else begin
                    nxt_o = q_q - 4'd1;
                end
            end
        end
    end

    always_comb begin
        q_d = nxt_o;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = load_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - BCD stopwatch/countdown timer with lap capture buffer
//
// Purpose : hundredths-resolution stopwatch for the service layer. Counts up
//           or down in BCD, captures laps into a small buffer and hands
//           control back via finish when the mode switch drops.
// Ports   : clk, resetn   - clock, synchronous active-low reset
//           en            - mode switch level, low forces IDLE
//           btn_ss        - start/stop pulse
//           btn_lap       - lap (RUN) / clear (READY, PAUSE, DONE) pulse
//           down          - count direction, sampled on start
//           preset_we     - load preset seconds (READY only)
//           preset        - BCD seconds preset
//           lap_rd_idx    - lap slot to read
//           time_bcd      - current time, MS digit first
//           lap_bcd       - selected lap slot (0 if slot not valid)
//           lap_count     - valid laps, saturates at LAP_DEPTH
//           running       - high in RUN
//           led           - registered copy of en
//           done          - one-cycle pulse when the countdown hits zero
//           finish        - registered, high while en is low
import stopwatch_pkg::*;

module lap_stopwatch #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int SEC_DIGITS = 2,
    parameter int LAP_DEPTH  = 4,
    localparam int LW        = $clog2(LAP_DEPTH),
    localparam int ND        = SEC_DIGITS + FRAC_DIGITS,
    localparam int TW        = BCD_W * ND
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        en,
    input  logic                        btn_ss,
    input  logic                        btn_lap,
    input  logic                        down,
    input  logic                        preset_we,
    input  logic [BCD_W*SEC_DIGITS-1:0] preset,
    input  logic [LW-1:0]               lap_rd_idx,
    output logic [TW-1:0]               time_bcd,
    output logic [TW-1:0]               lap_bcd,
    output logic [LW:0]                 lap_count,
    output logic                        running,
    output logic                        led,
    output logic                        done,
    output logic                        finish
);

    localparam int DIV = CLK_FREQ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_e         state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    logic              led_q, finish_q;
    logic [LW:0]       lap_cnt_q, lap_cnt_d;
    logic [TW-1:0]     lap_q [LAP_DEPTH];

    logic [TW-1:0]     time_cur;
    logic [TW-1:0]     time_nxt;
    logic [ND-1:0]     cin;
    logic [ND-1:0]     cout;
    logic [TW-1:0]     load_val;

    logic              tick;
    logic              zero_tick;
    logic              underflow;
    logic              clr_time;
    logic              clr_laps;
    logic              load_pre;
    logic              lap_cap;
    logic              lap_ok;

    assign tick = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));

    // A borrow out of the top digit can only mean counting below zero; it is
    // folded into the zero condition so the timer stops at 0 rather than
    // wrapping to all nines.
    assign underflow = dir_q && cout[ND-1];
    assign zero_tick = tick && dir_q && ((time_nxt == '0) || underflow);

    // Ripple chain: hundredths digit first, each carry/borrow feeds the next.
    assign cin[0] = tick;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_digit
            if (g + 1 < ND) begin : g_chain
                assign cin[g+1] = cout[g];
            end
            if (g < FRAC_DIGITS) begin : g_frac
                assign load_val[BCD_W*g +: BCD_W] = '0;
            end else begin : g_sec
                assign load_val[BCD_W*g +: BCD_W] =
                    bcd_clamp(preset[BCD_W*(g-FRAC_DIGITS) +: BCD_W]);
            end
            bcd_digit u_digit (
                .clk        (clk),
                .resetn     (resetn),
                .clr_i      (clr_time),
                .load_i     (load_pre),
                .load_val_i (load_val[BCD_W*g +: BCD_W]),
                .cin_i      (cin[g]),
                .up_i       (~dir_q),
                .q_o        (time_cur[BCD_W*g +: BCD_W]),
                .nxt_o      (time_nxt[BCD_W*g +: BCD_W]),
                .cout_o     (cout[g])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        clr_time = 1'b0;
        clr_laps = 1'b0;
        load_pre = 1'b0;
        lap_cap  = 1'b0;
        if (!en) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            clr_time = 1'b1;
            clr_laps = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_READY;
                    clr_time = 1'b1;
                    clr_laps = 1'b1;
                end
                ST_READY: begin
                    presc_d = '0;
                    if (btn_ss) begin
                        dir_d = down;
                        // Counting down from zero has nothing to run.
                        if (down && (time_cur == '0)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (btn_lap) begin
                        clr_time = 1'b1;
                        clr_laps = 1'b1;
                    end else if (preset_we) begin
                        load_pre = 1'b1;
                    end
                end
                ST_RUN: begin
                    presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + 1'b1;
                    if (zero_tick) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        clr_time = 1'b1;
                    end else begin
                        if (btn_ss) begin
                            state_d = ST_PAUSE;
                        end
                        if (btn_lap) begin
                            lap_cap = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_ss) begin
                        state_d = ST_RUN;
                    end else if (btn_lap) begin
                        state_d  = ST_READY;
                        clr_time = 1'b1;
                        clr_laps = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (btn_ss || btn_lap) begin
                        state_d  = ST_READY;
                        clr_time = 1'b1;
                        clr_laps = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign lap_ok = lap_cap && (lap_cnt_q < (LW+1)'(LAP_DEPTH));

    always_comb begin
        lap_cnt_d = lap_cnt_q;
        if (clr_laps) begin
            lap_cnt_d = '0;
        end else if (lap_ok) begin
            lap_cnt_d = lap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= 1'b0;
            finish_q  <= 1'b0;
            lap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            led_q     <= en;
            finish_q  <= ~en;
            lap_cnt_q <= lap_cnt_d;
        end
    end

    // Lap slots are zeroed on every clear so stale laps never reappear.
    always_ff @(posedge clk) begin
        if (!resetn || clr_laps) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_q[i] <= '0;
            end
        end else if (lap_ok) begin
            lap_q[lap_cnt_q[LW-1:0]] <= time_cur;
        end
    end

    assign lap_bcd   = ({1'b0, lap_rd_idx} < lap_cnt_q) ? lap_q[lap_rd_idx] : '0;
    assign time_bcd  = time_cur;
    assign lap_count = lap_cnt_q;
    assign running   = (state_q == ST_RUN);
    assign led       = led_q;
    assign done      = done_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb/tb_lap_stopwatch.sv - directed self-checking bench for lap_stopwatch
module tb_lap_stopwatch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_lap = 1'b0;
    logic        down = 1'b0;
    logic        preset_we = 1'b0;
    logic [7:0]  preset = 8'h00;
    logic [1:0]  lap_rd_idx = 2'd0;
    logic [15:0] time_bcd;
    logic [15:0] lap_bcd;
    logic [2:0]  lap_count;
    logic        running;
    logic        led;
    logic        done;
    logic        finish;

    int checks = 0;
    int errors = 0;

    lap_stopwatch #(
        .CLK_FREQ   (1000),
        .SEC_DIGITS (2),
        .LAP_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .down       (down),
        .preset_we  (preset_we),
        .preset     (preset),
        .lap_rd_idx (lap_rd_idx),
        .time_bcd   (time_bcd),
        .lap_bcd    (lap_bcd),
        .lap_count  (lap_count),
        .running    (running),
        .led        (led),
        .done       (done),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        btn_ss = 1'b1;
        cyc(1);
        btn_ss = 1'b0;
    endtask

    task automatic pulse_lap();
        btn_lap = 1'b1;
        cyc(1);
        btn_lap = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        en = 1'b0;
        cyc(2);
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL reset_time: got %h want 0000", time_bcd); errors++; end
        checks++; if (lap_count !== 3'd0) begin $display("FAIL reset_lap_count: got %0d want 0", lap_count); errors++; end
        checks++; if (lap_bcd !== 16'h0000) begin $display("FAIL reset_lap_bcd: got %h want 0000", lap_bcd); errors++; end
        checks++; if ({running, led, done, finish} !== 4'b0000) begin $display("FAIL reset_flags: got %b want 0000", {running, led, done, finish}); errors++; end
        resetn = 1'b1;
        cyc(1);
        checks++; if ({led, finish} !== 2'b01) begin $display("FAIL idle_led_finish: got %b want 01", {led, finish}); errors++; end
        en = 1'b1;
        cyc(1);
        checks++; if ({led, finish} !== 2'b10) begin $display("FAIL en_led_finish: got %b want 10", {led, finish}); errors++; end
        cyc(1);
    endtask

    task automatic test_up_count();
        pulse_ss();
        checks++; if (running !== 1'b1) begin $display("FAIL up_start_running: got %b want 1", running); errors++; end
        cyc(9);
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL up_before_first_tick: got %h want 0000", time_bcd); errors++; end
        cyc(1);
        checks++; if (time_bcd !== 16'h0001) begin $display("FAIL up_first_tick: got %h want 0001", time_bcd); errors++; end
        cyc(990);
        checks++; if (time_bcd !== 16'h0100) begin $display("FAIL up_one_second: got %h want 0100", time_bcd); errors++; end
        pulse_ss();
        checks++; if (running !== 1'b0) begin $display("FAIL up_pause_running: got %b want 0", running); errors++; end
        pulse_lap();
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL up_clear_time: got %h want 0000", time_bcd); errors++; end
    endtask

    task automatic test_preset_wrap();
        preset = 8'hA5;
        preset_we = 1'b1;
        cyc(1);
        preset_we = 1'b0;
        checks++; if (time_bcd !== 16'h9500) begin $display("FAIL preset_clamp: got %h want 9500", time_bcd); errors++; end
        pulse_lap();
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL ready_clear: got %h want 0000", time_bcd); errors++; end
        preset = 8'h99;
        preset_we = 1'b1;
        cyc(1);
        preset_we = 1'b0;
        checks++; if (time_bcd !== 16'h9900) begin $display("FAIL preset_99: got %h want 9900", time_bcd); errors++; end
        pulse_ss();
        cyc(990);
        checks++; if (time_bcd !== 16'h9999) begin $display("FAIL wrap_all_nines: got %h want 9999", time_bcd); errors++; end
        cyc(10);
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL wrap_to_zero: got %h want 0000", time_bcd); errors++; end
        checks++; if (running !== 1'b1) begin $display("FAIL wrap_keeps_running: got %b want 1", running); errors++; end
        pulse_ss();
        pulse_lap();
    endtask

    task automatic test_pause_resume();
        pulse_ss();
        cyc(50);
        checks++; if (time_bcd !== 16'h0005) begin $display("FAIL pr_tick5: got %h want 0005", time_bcd); errors++; end
        cyc(3);
        pulse_ss();
        checks++; if (running !== 1'b0) begin $display("FAIL pr_paused: got %b want 0", running); errors++; end
        preset = 8'h42;
        preset_we = 1'b1;
        cyc(1);
        preset_we = 1'b0;
        cyc(49);
        checks++; if (time_bcd !== 16'h0005) begin $display("FAIL pr_hold_and_preset_ignored: got %h want 0005", time_bcd); errors++; end
        pulse_ss();
        checks++; if (running !== 1'b1) begin $display("FAIL pr_resumed: got %b want 1", running); errors++; end
        cyc(5);
        checks++; if (time_bcd !== 16'h0005) begin $display("FAIL pr_no_early_tick: got %h want 0005", time_bcd); errors++; end
        cyc(1);
        checks++; if (time_bcd !== 16'h0006) begin $display("FAIL pr_tick6: got %h want 0006", time_bcd); errors++; end
        cyc(9);
        checks++; if (time_bcd !== 16'h0006) begin $display("FAIL pr_no_extra_tick: got %h want 0006", time_bcd); errors++; end
        cyc(1);
        checks++; if (time_bcd !== 16'h0007) begin $display("FAIL pr_tick7: got %h want 0007", time_bcd); errors++; end
        pulse_ss();
        pulse_lap();
    endtask

    task automatic test_laps();
        logic [15:0] exp_lap;
        pulse_ss();
        cyc(20);
        for (int k = 0; k < 5; k++) begin
            pulse_lap();
            cyc(19);
        end
        checks++; if (lap_count !== 3'd4) begin $display("FAIL lap_count_sat: got %0d want 4", lap_count); errors++; end
        for (int i = 0; i < 4; i++) begin
            lap_rd_idx = 2'(i);
            exp_lap = 16'(2 * (i + 1));
            #1;
            checks++; if (lap_bcd !== exp_lap) begin $display("FAIL lap_slot%0d: got %h want %h", i, lap_bcd, exp_lap); errors++; end
        end
        pulse_ss();
        pulse_lap();
        lap_rd_idx = 2'd0;
        #1;
        checks++; if (lap_count !== 3'd0) begin $display("FAIL lap_clear_count: got %0d want 0", lap_count); errors++; end
        checks++; if (lap_bcd !== 16'h0000) begin $display("FAIL lap_clear_slot: got %h want 0000", lap_bcd); errors++; end
    endtask

    task automatic test_clear_priority();
        pulse_ss();
        cyc(30);
        btn_ss = 1'b1;
        btn_lap = 1'b1;
        cyc(1);
        btn_ss = 1'b0;
        btn_lap = 1'b0;
        checks++; if (running !== 1'b0) begin $display("FAIL prio_paused: got %b want 0", running); errors++; end
        checks++; if (lap_count !== 3'd1) begin $display("FAIL prio_lap_count: got %0d want 1", lap_count); errors++; end
        checks++; if (lap_bcd !== 16'h0003) begin $display("FAIL prio_lap_value: got %h want 0003", lap_bcd); errors++; end
        cyc(20);
        checks++; if (time_bcd !== 16'h0003) begin $display("FAIL prio_time_held: got %h want 0003", time_bcd); errors++; end
        pulse_lap();
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL pause_clear_time: got %h want 0000", time_bcd); errors++; end
        checks++; if (lap_count !== 3'd0) begin $display("FAIL pause_clear_laps: got %0d want 0", lap_count); errors++; end
        pulse_ss();
        checks++; if (running !== 1'b1) begin $display("FAIL clear_to_ready_start: got %b want 1", running); errors++; end
        pulse_ss();
        pulse_lap();
    endtask

    task automatic test_countdown();
        preset = 8'h01;
        preset_we = 1'b1;
        cyc(1);
        preset_we = 1'b0;
        down = 1'b1;
        pulse_ss();
        checks++; if (running !== 1'b1) begin $display("FAIL cd_running: got %b want 1", running); errors++; end
        cyc(10);
        checks++; if (time_bcd !== 16'h0099) begin $display("FAIL cd_first_borrow: got %h want 0099", time_bcd); errors++; end
        cyc(980);
        checks++; if ({time_bcd, done, running} !== {16'h0001, 2'b01}) begin $display("FAIL cd_before_zero: got %h/%b%b want 0001/01", time_bcd, done, running); errors++; end
        cyc(10);
        checks++; if ({time_bcd, done, running} !== {16'h0000, 2'b10}) begin $display("FAIL cd_zero_done: got %h/%b%b want 0000/10", time_bcd, done, running); errors++; end
        cyc(1);
        checks++; if (done !== 1'b0) begin $display("FAIL cd_done_one_cycle: got %b want 0", done); errors++; end
        cyc(5);
        checks++; if ({time_bcd, running} !== {16'h0000, 1'b0}) begin $display("FAIL cd_stays_done: got %h/%b want 0000/0", time_bcd, running); errors++; end
        pulse_ss();
        checks++; if ({done, running} !== 2'b00) begin $display("FAIL cd_done_to_ready: got %b want 00", {done, running}); errors++; end
        pulse_ss();
        checks++; if ({done, running} !== 2'b10) begin $display("FAIL cd_zero_start_done: got %b want 10", {done, running}); errors++; end
        cyc(1);
        checks++; if (done !== 1'b0) begin $display("FAIL cd_zero_start_pulse: got %b want 0", done); errors++; end
        pulse_lap();
        down = 1'b0;
    endtask

    task automatic test_switch_reset();
        pulse_ss();
        cyc(25);
        checks++; if (time_bcd !== 16'h0002) begin $display("FAIL sw_mid_run: got %h want 0002", time_bcd); errors++; end
        en = 1'b0;
        cyc(1);
        checks++; if ({running, finish, led} !== 3'b010) begin $display("FAIL sw_en_low: got %b want 010", {running, finish, led}); errors++; end
        checks++; if (time_bcd !== 16'h0000) begin $display("FAIL sw_idle_time: got %h want 0000", time_bcd); errors++; end
        en = 1'b1;
        cyc(1);
        pulse_ss();
        cyc(20);
        pulse_lap();
        cyc(14);
        checks++; if ({time_bcd, lap_count} !== {16'h0003, 3'd1}) begin $display("FAIL rst_pre: got %h/%0d want 0003/1", time_bcd, lap_count); errors++; end
        resetn = 1'b0;
        cyc(1);
        checks++; if ({time_bcd, lap_count, lap_bcd} !== {16'h0000, 3'd0, 16'h0000}) begin $display("FAIL rst_mid_count_data: got %h/%0d/%h want 0000/0/0000", time_bcd, lap_count, lap_bcd); errors++; end
        checks++; if ({running, led, done, finish} !== 4'b0000) begin $display("FAIL rst_mid_count_flags: got %b want 0000", {running, led, done, finish}); errors++; end
        resetn = 1'b1;
        cyc(2);
    endtask

    initial begin
        #1;
        test_reset();
        test_up_count();
        test_preset_wrap();
        test_pause_resume();
        test_laps();
        test_clear_priority();
        test_countdown();
        test_switch_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
